// File: rtl/picomem_pkg.sv
// Shared PicoMem definitions: arbiter state encoding, timeout counter width,
// default error read data and the tie-break helper.
package picomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_M0 = 2'd1,
    ST_BUSY_M1 = 2'd2
  } arb_state_e;

  localparam int unsigned CNT_W = 16;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // Returns 1 when m1 should be granted. A lone requester always wins; on a
  // tie m0 wins under fixed priority, otherwise the master not served last.
  function automatic logic pick_m1(input logic v0, input logic v1,
                                   input logic fixed_prio, input logic last_grant);
    if (v0 && v1) begin
      return fixed_prio ? 1'b0 : ~last_grant;
    end
    return v1 && !v0;
  endfunction

endpackage

// File: rtl/picomem_timeout_cnt.sv
// Busy-cycle counter for the arbiter watchdog. Cleared while the arbiter is
// idle, counts stalled cycles, and flags the cycle in which the count reaches
// TIMEOUT-1. TIMEOUT=0 keeps expire low permanently.
module picomem_timeout_cnt
  import picomem_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT = 16'd1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST_CNT = TIMEOUT - 16'd1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority so the count always starts at zero on BUSY entry.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (TIMEOUT != '0) && (cnt_q == LAST_CNT);

endmodule

// File: rtl/picomem_arbiter_2_1.sv
// Two-master to one-slave PicoMem arbiter with round-robin or fixed priority
// and a watchdog that force-completes a stalled transfer with ERR_RDATA.
// No data is buffered: the slave request is a mux on the registered grant.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no grant; slave request and all master responses are zero
//   ST_BUSY_M0 | m0 owns the slave until s_ready, timeout or m0_valid drop
//   ST_BUSY_M1 | m1 owns the slave until s_ready, timeout or m1_valid drop
module picomem_arbiter_2_1
  import picomem_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT    = 16'd1024,
  parameter logic             FIXED_PRIO = 1'b0,
  parameter logic [31:0]      ERR_RDATA  = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        timeout_err
);

  arb_state_e  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        cnt_clear, cnt_en, tmo_expire;
  logic        gnt_m1, gnt_valid, done;
  logic [31:0] done_rdata;

  picomem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .expire (tmo_expire)
  );

  // Arbitration, slave request mux and completion routing back to the owner.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_m1       = (state_q == ST_BUSY_M1);
    gnt_valid    = 1'b0;
    done         = 1'b0;
    done_rdata   = '0;
    cnt_clear    = 1'b1;
    cnt_en       = 1'b0;
    s_valid      = 1'b0;
    s_addr       = '0;
    s_wdata      = '0;
    s_wstrb      = '0;
    timeout_err  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = pick_m1(m0_valid, m1_valid, FIXED_PRIO, last_grant_q)
                    ? ST_BUSY_M1 : ST_BUSY_M0;
        end
      end
      ST_BUSY_M0, ST_BUSY_M1: begin
        gnt_valid = gnt_m1 ? m1_valid : m0_valid;
        s_addr    = gnt_m1 ? m1_addr  : m0_addr;
        s_wdata   = gnt_m1 ? m1_wdata : m0_wdata;
        s_wstrb   = gnt_m1 ? m1_wstrb : m0_wstrb;
        s_valid   = gnt_valid;
        cnt_clear = 1'b0;
        cnt_en    = gnt_valid && !s_ready;
        if (!gnt_valid) begin
          // Master withdrew its request: drop the grant silently.
          state_d = ST_IDLE;
        end else if (s_ready) begin
          done       = 1'b1;
          done_rdata = s_rdata;
        end else if (tmo_expire) begin
          done        = 1'b1;
          done_rdata  = ERR_RDATA;
          s_valid     = 1'b0;
          timeout_err = 1'b1;
        end
        if (done) begin
          state_d      = ST_IDLE;
          last_grant_d = gnt_m1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    m0_ready = done && !gnt_m1;
    m1_ready = done && gnt_m1;
    m0_rdata = m0_ready ? done_rdata : '0;
    m1_rdata = m1_ready ? done_rdata : '0;
  end

  // State and last-grant registers; last_grant=1 lets m0 win the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_picomem_arbiter_2_1.sv
// Scoreboard bench: directed requests are queued to master models and the
// hand-computed completions to expectation queues; monitors pop and compare
// on every ready pulse.
module tb_picomem_arbiter_2_1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    logic        mst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        to;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // main instance: round robin, TIMEOUT=8
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_ready, m1_ready, s_valid, timeout_err;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = '0;

  // fixed-priority instance, timeout disabled
  logic        fm0_valid = 1'b0, fm1_valid = 1'b0;
  logic [31:0] fm0_addr = 32'h3000_0000, fm1_addr = 32'h4000_0000;
  logic [31:0] fm0_wdata = 32'hA0A0_A0A0, fm1_wdata = 32'hB0B0_B0B0;
  logic [3:0]  fm0_wstrb = 4'h3, fm1_wstrb = 4'hC;
  logic        fm0_ready, fm1_ready, fs_valid, ftimeout_err;
  logic [31:0] fm0_rdata, fm1_rdata, fs_addr, fs_wdata;
  logic [3:0]  fs_wstrb;
  logic        fs_ready = 1'b1;
  logic [31:0] fs_rdata = 32'h0F0F_0F0F;

  int checks = 0;
  int errors = 0;

  req_t m0_q[$], m1_q[$];
  exp_t exp_q[$], fexp_q[$];
  int   slave_lat = -1;
  logic drop0 = 1'b0;

  always #5 clk = ~clk;

  picomem_arbiter_2_1 #(.TIMEOUT(16'd8), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata), .timeout_err(timeout_err)
  );

  picomem_arbiter_2_1 #(.TIMEOUT(16'd0), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_valid(fm0_valid), .m0_addr(fm0_addr), .m0_wdata(fm0_wdata), .m0_wstrb(fm0_wstrb),
    .m0_ready(fm0_ready), .m0_rdata(fm0_rdata),
    .m1_valid(fm1_valid), .m1_addr(fm1_addr), .m1_wdata(fm1_wdata), .m1_wstrb(fm1_wstrb),
    .m1_ready(fm1_ready), .m1_rdata(fm1_rdata),
    .s_valid(fs_valid), .s_addr(fs_addr), .s_wdata(fs_wdata), .s_wstrb(fs_wstrb),
    .s_ready(fs_ready), .s_rdata(fs_rdata), .timeout_err(ftimeout_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic mst, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] rdata,
                          input logic to, input int cyc);
    exp_q.push_back('{mst, addr, wdata, wstrb, rdata, to, cyc});
  endtask

  task automatic wait_done(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0 && fexp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0 || fexp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain pending %0d/%0d completions, expected 0", name,
               exp_q.size(), fexp_q.size());
      exp_q.delete();
      fexp_q.delete();
    end
  endtask

  // Master and slave models: sample mid-cycle, update just after the edge.
  always begin : bfm
    logic r0, r1, sv, sr;
    int   cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      r0 = m0_ready; r1 = m1_ready; sv = s_valid; sr = s_ready;
      @(posedge clk);
      #1;
      if (r0 && m0_q.size() != 0) void'(m0_q.pop_front());
      if (r1 && m1_q.size() != 0) void'(m1_q.pop_front());
      if (drop0 && m0_q.size() != 0) void'(m0_q.pop_front());
      drop0 = 1'b0;
      if (m0_q.size() != 0) begin
        m0_valid = 1'b1; m0_addr = m0_q[0].addr; m0_wdata = m0_q[0].wdata; m0_wstrb = m0_q[0].wstrb;
      end else begin
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
      end
      if (m1_q.size() != 0) begin
        m1_valid = 1'b1; m1_addr = m1_q[0].addr; m1_wdata = m1_q[0].wdata; m1_wstrb = m1_q[0].wstrb;
      end else begin
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
      end
      if (reset) cnt = 0;
      else if (sv && !sr) cnt++;
      else cnt = 0;
      s_ready = (slave_lat >= 0) && (cnt == slave_lat);
    end
  end

  // Monitor for the round-robin instance.
  always @(negedge clk) begin : mon
    exp_t e;
    int   busy;
    if (reset) begin
      busy = 0;
    end else begin
      if (s_valid || m0_ready || m1_ready) busy++;
      else busy = 0;
      if (m0_ready || m1_ready || timeout_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion m0_ready=%b m1_ready=%b timeout_err=%b, expected none",
                   m0_ready, m1_ready, timeout_err);
        end else begin
          e = exp_q.pop_front();
          chkb("grant_master", m1_ready, e.mst);
          chkb("single_ready", m0_ready ^ m1_ready, 1'b1);
          chk("rdata", e.mst ? m1_rdata : m0_rdata, e.rdata);
          chk("other_rdata", e.mst ? m0_rdata : m1_rdata, 32'h0);
          chkb("timeout_err", timeout_err, e.to);
          if (e.to) begin
            chkb("s_valid_on_timeout", s_valid, 1'b0);
          end else begin
            chk("s_addr", s_addr, e.addr);
            chk("s_wdata", s_wdata, e.wdata);
            chk("s_wstrb", {28'h0, s_wstrb}, {28'h0, e.wstrb});
          end
          chk("busy_cycles", busy, e.cyc);
        end
        busy = 0;
      end
    end
  end

  // Monitor for the fixed-priority instance.
  always @(negedge clk) begin : fmon
    exp_t e;
    int   busy;
    if (reset) begin
      busy = 0;
    end else begin
      if (fs_valid || fm0_ready || fm1_ready) busy++;
      else busy = 0;
      if (fm0_ready || fm1_ready || ftimeout_err) begin
        if (fexp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fp_unexpected_completion m0_ready=%b m1_ready=%b, expected none",
                   fm0_ready, fm1_ready);
        end else begin
          e = fexp_q.pop_front();
          chkb("fp_grant_master", fm1_ready, e.mst);
          chk("fp_rdata", e.mst ? fm1_rdata : fm0_rdata, e.rdata);
          chk("fp_s_addr", fs_addr, e.addr);
          chkb("fp_timeout_err", ftimeout_err, 1'b0);
          chk("fp_busy_cycles", busy, e.cyc);
        end
        busy = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset with requests active on the fixed-priority instance.
    fm0_valid = 1'b1;
    fm1_valid = 1'b1;
    repeat (3) @(negedge clk);
    chkb("rst_s_valid", s_valid, 1'b0);
    chkb("rst_m0_ready", m0_ready, 1'b0);
    chkb("rst_m1_ready", m1_ready, 1'b0);
    chkb("rst_timeout_err", timeout_err, 1'b0);
    chkb("rst_fp_s_valid", fs_valid, 1'b0);
    chkb("rst_fp_m0_ready", fm0_ready, 1'b0);
    chk("rst_fp_s_addr", fs_addr, 32'h0);
    chk("rst_fp_s_wdata", fs_wdata, 32'h0);
    chk("rst_fp_m0_rdata", fm0_rdata, 32'h0);

    // Fixed priority: m0 wins four times while m1 keeps requesting.
    for (int i = 0; i < 4; i++)
      fexp_q.push_back('{1'b0, 32'h3000_0000, 32'hA0A0_A0A0, 4'h3, 32'h0F0F_0F0F, 1'b0, 1});
    reset = 1'b0;
    wait_done("fixed_prio", 40);
    @(posedge clk);
    #1;
    fm0_valid = 1'b0;
    fm1_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Round robin from reset: m0, m1, m0, m1.
    slave_lat = 0;
    s_rdata = 32'hCAFE_0001;
    m0_q.push_back('{32'h0000_1000, 32'h1111_1111, 4'hF});
    m0_q.push_back('{32'h0000_1004, 32'h0000_0000, 4'h0});
    m1_q.push_back('{32'h0000_2000, 32'h0000_0000, 4'h0});
    m1_q.push_back('{32'h0000_2004, 32'h2222_2222, 4'h3});
    push_exp(1'b0, 32'h0000_1000, 32'h1111_1111, 4'hF, 32'hCAFE_0001, 1'b0, 1);
    push_exp(1'b1, 32'h0000_2000, 32'h0000_0000, 4'h0, 32'hCAFE_0001, 1'b0, 1);
    push_exp(1'b0, 32'h0000_1004, 32'h0000_0000, 4'h0, 32'hCAFE_0001, 1'b0, 1);
    push_exp(1'b1, 32'h0000_2004, 32'h2222_2222, 4'h3, 32'hCAFE_0001, 1'b0, 1);
    wait_done("round_robin", 40);
    repeat (3) @(negedge clk);

    // m0 alone, slave ready in the third s_valid cycle.
    slave_lat = 2;
    s_rdata = 32'h1234_5678;
    m0_q.push_back('{32'h0000_0100, 32'h0, 4'h0});
    push_exp(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 3);
    @(posedge m0_valid);
    @(negedge clk);
    chkb("arb_latency_idle", s_valid, 1'b0);
    @(negedge clk);
    chkb("arb_latency_busy", s_valid, 1'b1);
    wait_done("m0_single", 40);
    repeat (3) @(negedge clk);

    // Ready arrives in the 8th cycle, same cycle the timeout would fire.
    slave_lat = 7;
    s_rdata = 32'h5555_AAAA;
    m1_q.push_back('{32'h0000_3000, 32'h3333_0000, 4'hC});
    push_exp(1'b1, 32'h0000_3000, 32'h3333_0000, 4'hC, 32'h5555_AAAA, 1'b0, 8);
    wait_done("ready_at_limit", 40);
    repeat (3) @(negedge clk);

    // Slave never answers: forced completion with error data.
    slave_lat = -1;
    m1_q.push_back('{32'h0000_3004, 32'h0, 4'h0});
    push_exp(1'b1, 32'h0000_3004, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, 8);
    wait_done("timeout", 40);
    repeat (3) @(negedge clk);
    chkb("idle_after_timeout", s_valid, 1'b0);

    // m0 withdraws mid-transfer; last grant stays m1, so m0 wins the next tie.
    m0_q.push_back('{32'h0000_5000, 32'h0, 4'h0});
    repeat (4) @(negedge clk);
    chkb("violation_busy", s_valid, 1'b1);
    drop0 = 1'b1;
    repeat (4) @(negedge clk);
    chkb("violation_idle", s_valid, 1'b0);
    slave_lat = 0;
    s_rdata = 32'h7777_0001;
    m0_q.push_back('{32'h0000_5100, 32'h0, 4'h0});
    m1_q.push_back('{32'h0000_5200, 32'h0, 4'h0});
    push_exp(1'b0, 32'h0000_5100, 32'h0, 4'h0, 32'h7777_0001, 1'b0, 1);
    push_exp(1'b1, 32'h0000_5200, 32'h0, 4'h0, 32'h7777_0001, 1'b0, 1);
    wait_done("after_violation", 40);
    repeat (3) @(negedge clk);

    // Reset during BUSY_M1 aborts immediately; m0 wins the first tie after.
    slave_lat = -1;
    m1_q.push_back('{32'h0000_6000, 32'h0, 4'h0});
    repeat (4) @(negedge clk);
    chkb("pre_reset_busy", s_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chkb("async_rst_s_valid", s_valid, 1'b0);
    chkb("async_rst_m1_ready", m1_ready, 1'b0);
    chk("async_rst_m1_rdata", m1_rdata, 32'h0);
    chk("async_rst_s_addr", s_addr, 32'h0);
    chkb("async_rst_timeout_err", timeout_err, 1'b0);
    slave_lat = 0;
    s_rdata = 32'h8888_0002;
    m0_q.push_back('{32'h0000_6100, 32'h0, 4'h0});
    push_exp(1'b0, 32'h0000_6100, 32'h0, 4'h0, 32'h8888_0002, 1'b0, 1);
    push_exp(1'b1, 32'h0000_6000, 32'h0, 4'h0, 32'h8888_0002, 1'b0, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_done("after_reset", 40);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/picomem_arbiter_2_1.md
PICOMEM_ARBITER_2_1 -- requirements
Module: picomem_arbiter_2_1

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd1024: number of BUSY cycles without s_ready before a forced completion; 0 disables the timeout.
REQ-002 SHALL have parameter FIXED_PRIO, default 1'b0: 0 selects round-robin, 1 gives m0 absolute priority.
REQ-003 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned on a timeout.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Ports m0_valid in 1, m0_addr in 32, m0_wdata in 32, m0_wstrb in 4, m0_ready out 1, m0_rdata out 32: PicoMem master port 0 (CPU).
REQ-007 Ports m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: master port 1 (DMA/video); same directions and widths as m0.
REQ-008 Ports s_valid out 1, s_addr out 32, s_wdata out 32, s_wstrb out 4, s_ready in 1, s_rdata in 32: shared PicoMem slave port.
REQ-009 Port timeout_err, output, 1: one-cycle pulse on each forced completion.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY_M0, BUSY_M1.
REQ-011 IDLE: if exactly one mX_valid is high, go to BUSY_MX; if both are high, the winner is m0 when FIXED_PRIO=1, otherwise the master not in last_grant; if neither is high, stay in IDLE.
REQ-012 Arbitration latency: s_valid SHALL rise exactly one cycle after the winning valid is sampled in IDLE.
REQ-013 BUSY_MX: s_valid = mX_valid; s_addr/s_wdata/s_wstrb = mX fields (combinational mux on the registered grant); in IDLE, s_valid=0 and the s_* fields are 0.
REQ-014 BUSY_MX with s_ready=1: mX_ready=1 in the same cycle; mX_rdata=s_rdata; next state IDLE; last_grant<=X.
REQ-015 The non-granted master SHALL see ready=0 and rdata=0 at all times; s_ready in IDLE SHALL be ignored.
REQ-016 Back-to-back: the master that just completed cannot be re-granted before IDLE; in round-robin mode, when both masters request, grants SHALL alternate.
REQ-017 Timeout: a 16-bit counter clears on BUSY entry and increments each BUSY cycle with s_ready=0.
REQ-018 When TIMEOUT!=0 and the count equals TIMEOUT-1 while s_ready=0: mX_ready=1, mX_rdata=ERR_RDATA, s_valid=0, timeout_err=1 that cycle; next state IDLE; last_grant<=X.
REQ-019 s_ready=1 in the timeout cycle: the normal completion SHALL win and timeout_err stays 0.
REQ-020 Granted mX_valid falling in BUSY without ready (protocol violation): go to IDLE next cycle, no ready pulse, last_grant unchanged.
REQ-021 A write (wstrb!=0) and a read SHALL be handled identically; the arbiter never alters wstrb or address.

Reset
REQ-022 On reset: state=IDLE, last_grant=1 (m0 wins the first tie), counter=0.
REQ-023 While reset is high: s_valid, m0_ready, m1_ready and timeout_err are 0, and all data outputs are 0.
REQ-024 Reset asserted mid-transaction SHALL abort it immediately, with no ready pulse to any master.

Structure
REQ-025 The FSM state encoding and the ERR_RDATA default SHALL live in shared package picomem_pkg for reuse by other PicoMem infrastructure.
REQ-026 The timeout counter SHALL be a sub-module, picomem_timeout_cnt (ports: clk, reset, clear, enable, expire).
REQ-027 The block SHALL be register-light: state, last_grant and counter only, with no data buffering.

Verification
REQ-028 m0 read alone, slave ready 2 cycles after s_valid, s_rdata=32'h1234_5678 -> m0_ready pulse of 1 cycle carrying 32'h1234_5678, m1_ready=0 throughout.
REQ-029 m0 and m1 both valid from reset, slave ready at 1 cycle -> grant order m0, m1, m0, m1, with s_addr following each master's address.
REQ-030 FIXED_PRIO=1, both valid continuously for 4 transactions -> m0 granted all 4 times, m1 starved.
REQ-031 TIMEOUT=8, s_ready held 0 -> m1_ready=1 with rdata 32'hDEAD_BEEF in the 8th BUSY cycle, timeout_err a single pulse, then IDLE.
REQ-032 TIMEOUT=8, s_ready=1 in the 8th cycle -> normal completion, timeout_err=0.
REQ-033 Reset asserted during BUSY_M1 -> s_valid and m1_ready go low asynchronously; after release, m0 wins the first tie.
